// File: rtl/bmu_arb_pkg.sv
// bmu_arb_pkg: shared types for the two-port BMU arbiter.
//   bmu_op_e        - 4-bit request opcode (codes 4'hB..4'hF are illegal)
//   bmu_ap_t        - one-hot-ish BMU control bundle driven on bmu_ap
//   bmu_arb_state_e - arbiter FSM state, also exported on dbg_state
package bmu_arb_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_ANDN = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRA  = 4'h6,
    OP_BEXT = 4'h7,
    OP_SLT  = 4'h8,
    OP_SLTU = 4'h9,
    OP_MIN  = 4'hA
  } bmu_op_e;

  // Field order follows the BMU control bundle.
  typedef struct packed {
    logic land;
    logic lxor;
    logic sll;
    logic sra;
    logic add;
    logic sub;
    logic slt;
    logic unsign;
    logic min;
    logic bext;
    logic zbb;
  } bmu_ap_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } bmu_arb_state_e;

endpackage

// File: rtl/bmu_arb_op_decode.sv
// bmu_op_decode: combinational opcode -> BMU control bundle decode.
//   i_op    : 4-bit opcode (bmu_op_e encoding)
//   o_ap    : control bundle; exactly one operation bit except ANDN
//             (land+zbb) and SLTU (slt+unsign); all zero when illegal
//   o_legal : 1 when i_op is one of the supported opcodes
module bmu_op_decode
  import bmu_arb_pkg::*;
(
  input  logic [3:0] i_op,
  output bmu_ap_t    o_ap,
  output logic       o_legal
);

  always_comb begin
    o_ap    = '0;
    o_legal = 1'b1;
    case (i_op)
      OP_ADD:  o_ap.add  = 1'b1;
      OP_SUB:  o_ap.sub  = 1'b1;
      OP_AND:  o_ap.land = 1'b1;
      OP_ANDN: begin
        o_ap.land = 1'b1;
        o_ap.zbb  = 1'b1;
      end
      OP_XOR:  o_ap.lxor = 1'b1;
      OP_SLL:  o_ap.sll  = 1'b1;
      OP_SRA:  o_ap.sra  = 1'b1;
      OP_BEXT: o_ap.bext = 1'b1;
      OP_SLT:  o_ap.slt  = 1'b1;
      OP_SLTU: begin
        o_ap.slt    = 1'b1;
        o_ap.unsign = 1'b1;
      end
      OP_MIN:  o_ap.min  = 1'b1;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/bmu_arb.sv
// bmu_arb: round-robin arbiter sharing one BMU between two requesters.
// One operation in flight: IDLE (accept) -> EXEC (capture BMU result)
// -> RESP (hold response until the owner's rsp_ready).
//
// Handshake rule (all ports): a transfer happens at a rising clk edge where
// valid && ready are both high; the sender holds its payload stable while
// valid is high and ready is low. reqN_ready is combinational (IDLE only).
//
// Ports:
//   clk, rst_l                 - clock, synchronous active-low reset
//   reqN_valid/ready/a/b/op    - request channels, N = 0,1
//   rspN_valid/ready/result/error - response channels, N = 0,1
//   bmu_valid/a/b/ap           - operation to the BMU (accept cycle only)
//   bmu_result/bmu_error       - BMU registered result, sampled in EXEC
//   op_cnt, err_cnt            - saturating stats, only with BMU_ARB_STATS_EN
//   dbg_state                  - current FSM state (bmu_arb_state_e)
// Optional feature macro: BMU_ARB_STATS_EN.
module bmu_arb
  import bmu_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_l,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_error,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_error,
  output logic        bmu_valid,
  output logic [31:0] bmu_a,
  output logic [31:0] bmu_b,
  output bmu_ap_t     bmu_ap,
  input  logic [31:0] bmu_result,
  input  logic        bmu_error,
`ifdef BMU_ARB_STATS_EN
  output logic [15:0] op_cnt,
  output logic [15:0] err_cnt,
`endif
  output logic [1:0]  dbg_state
);

  bmu_arb_state_e r_state;
  logic           r_last_grant;  // 1 = req1 granted last
  logic           r_owner;
  logic           r_legal;
  logic [31:0]    r_result;
  logic           r_error;

  logic           w_pick1;
  logic           w_accept;
  logic [3:0]     w_op;
  bmu_ap_t        w_ap;
  logic           w_legal;
  logic           w_rsp_on;
  logic           w_rsp_fire;

  // req1 wins when it is alone, or when both ask and req0 went last.
  assign w_pick1  = req1_valid & (~req0_valid | ~r_last_grant);
  // Gated by rst_l so every output reads 0 while reset is asserted.
  assign w_accept = rst_l & (r_state == ST_IDLE) & (req0_valid | req1_valid);
  assign w_op     = w_pick1 ? req1_op : req0_op;

  bmu_op_decode u_dec (
    .i_op    (w_op),
    .o_ap    (w_ap),
    .o_legal (w_legal)
  );

  assign req0_ready = w_accept & ~w_pick1;
  assign req1_ready = w_accept & w_pick1;

  assign bmu_valid = w_accept & w_legal;
  assign bmu_a     = w_accept ? (w_pick1 ? req1_a : req0_a) : 32'd0;
  assign bmu_b     = w_accept ? (w_pick1 ? req1_b : req0_b) : 32'd0;
  assign bmu_ap    = w_accept ? w_ap : '0;

  assign w_rsp_on    = rst_l & (r_state == ST_RESP);
  // Only the owner's rsp_ready can close the response.
  assign w_rsp_fire  = w_rsp_on & (r_owner ? rsp1_ready : rsp0_ready);

  assign rsp0_valid  = w_rsp_on & ~r_owner;
  assign rsp1_valid  = w_rsp_on & r_owner;
  assign rsp0_result = rsp0_valid ? r_result : 32'd0;
  assign rsp1_result = rsp1_valid ? r_result : 32'd0;
  assign rsp0_error  = rsp0_valid & r_error;
  assign rsp1_error  = rsp1_valid & r_error;

  assign dbg_state = r_state;

`ifdef BMU_ARB_STATS_EN
  logic [15:0] r_op_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_op_cnt  <= 16'd0;
      r_err_cnt <= 16'd0;
    end else begin
      if (w_accept && (r_op_cnt != 16'hFFFF))
        r_op_cnt <= r_op_cnt + 16'd1;
      if (w_rsp_fire && r_error && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign op_cnt  = r_op_cnt;
  assign err_cnt = r_err_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_legal      <= 1'b0;
      r_result     <= 32'd0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_pick1;
            r_owner      <= w_pick1;
            r_legal      <= w_legal;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Illegal ops never reached the BMU; answer 0 with error.
          r_result <= r_legal ? bmu_result : 32'd0;
          r_error  <= r_legal ? bmu_error : 1'b1;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_fire) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bmu_arb.md
BMU_ARB -- requirements
Module: bmu_arb

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_l, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have ports reqN_valid (input, 1), reqN_ready (output, 1), reqN_a (input, 32), reqN_b (input, 32), reqN_op (input, 4, bmu_op_e), for N = 0, 1.
REQ-004 SHALL have ports rspN_valid (output, 1), rspN_ready (input, 1), rspN_result (output, 32), rspN_error (output, 1), for N = 0, 1.
REQ-005 SHALL have BMU-side ports bmu_valid (output, 1), bmu_a (output, 32), bmu_b (output, 32), bmu_ap (output, bmu_ap_t), bmu_result (input, 32), bmu_error (input, 1).

Function
REQ-006 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight at a time.
REQ-007 In IDLE, with any reqN_valid high, SHALL pick one winner and assert only that winner's reqN_ready, combinationally in the same cycle.
- reqN_ready SHALL be 0 in EXEC and RESP.
REQ-008 SHALL use round-robin arbitration.
- Both valid: grant the requester not granted last.
- Single valid: grant it.
- last_grant SHALL update only on an accepted handshake.
REQ-009 In the accept cycle, SHALL drive bmu_a/bmu_b from the winner's operands and bmu_ap from its decoded op; bmu_valid=1 only in accept cycles with a legal op, 0 in all other cycles.
REQ-010 Op decode SHALL set exactly one ap operation bit, with these exceptions:
- ANDN sets land+zbb.
- SLTU sets slt+unsign.
- Legal ops: ADD, SUB, AND, ANDN, XOR, SLL, SRA, BEXT, SLT, SLTU, MIN.
REQ-011 An illegal op code SHALL still be accepted, with bmu_valid=0; its response SHALL carry result 0, error 1, at normal latency.
REQ-012 In EXEC, SHALL capture bmu_result/bmu_error (legal op) or 0/1 (illegal op) into holding registers, and record the owner id.
REQ-013 In RESP, SHALL assert rsp_valid of the owner only, with result/error held stable until rsp_ready.
- Accept at edge N -> rsp_valid high in cycle N+2.
- Minimum throughput: one op per 3 cycles.
REQ-014 rsp_valid && rsp_ready at an edge SHALL return the FSM to IDLE, dropping rsp_valid the next cycle.
- rsp_ready already high on entry to RESP gives a one-cycle response.
REQ-015 A non-owner's rsp_ready SHALL be ignored; rspN_result/rspN_error SHALL be 0 whenever rspN_valid=0.
REQ-016 Requests arriving in EXEC or RESP SHALL wait (no drop), and are arbitrated on return to IDLE.

Reset
REQ-017 With rst_l low at an edge, SHALL go to IDLE and clear:
- last_grant = 1, so req0 wins first.
- holding registers and owner.
- counters, when present.
REQ-018 During and after reset, all outputs SHALL read 0: reqN_ready, rspN_*, bmu_*.
REQ-019 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.
- rst_l SHALL also be wired to the BMU, so its stale result_ff is also cleared.

Configuration
REQ-020 With BMU_ARB_STATS_EN defined, SHALL add outputs op_cnt (16) and err_cnt (16).
- op_cnt: +1 per accepted request.
- err_cnt: +1 per response delivered with error=1.
- Both saturate at 16'hFFFF.
REQ-021 Without BMU_ARB_STATS_EN, those ports and counters SHALL not exist; behaviour is otherwise identical.

Structure
REQ-022 Package bmu_arb_pkg SHALL hold bmu_op_e (4-bit enum), bmu_ap_t (packed struct matching the BMU control bundle, same field order), and the fsm state enum.
REQ-023 Op decode SHALL be one combinational sub-module, bmu_op_decode (op in -> ap out, legal flag out).

Verification
REQ-024 Scenario: req0 ADD a=7, b=5, rsp0_ready=1 -> rsp0_valid at N+2, result 12, error 0.
REQ-025 Scenario: req0 and req1 both valid continuously after reset -> grants 0,1,0,1; ops SUB 10-3 and XOR F0^0F give results 7 and FF.
REQ-026 Scenario: req1 ADD 32'h7FFFFFFF+1, rsp1_ready held 0 for 5 cycles -> result 32'h80000000, error 1, held stable for all 5 cycles; req0 is not readied meanwhile.
REQ-027 Scenario: req0 op=4'hF (illegal) -> bmu_valid never 1; response result 0, error 1.
REQ-028 Scenario: rst_l low in EXEC of SLTU 1<FFFFFFFF -> no response; next req0 SLTU 1<FFFFFFFF -> result 1.
REQ-029 Scenario (STATS_EN): 3 ops, one of them illegal -> op_cnt 3, err_cnt 1; preload near saturation -> counter stays at FFFF.
